// File: rtl/regbank_ctrl_pkg.sv
// rtl/regbank_ctrl_pkg.sv - shared types and helpers for the register-bank clear arbiter
//
// Purpose: clear-engine state encoding and the fill-pattern builder.
// Contents:
//   clr_state_e  CLR_IDLE / CLR_CLEAR / CLR_DONE
//   fill_word    returns fill_bit replicated into the low 'width' bits (rest zero)
package regbank_ctrl_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  // Upper bound on entry width the fill helper can build; callers slice the low bits.
  localparam int FILL_MAX_W = 1024;

  function automatic logic [FILL_MAX_W-1:0] fill_word(input int width, input logic fill_bit);
    logic [FILL_MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < FILL_MAX_W; i++) begin
      if (i < width) w[i] = fill_bit;
    end
    return w;
  endfunction

endpackage

// File: rtl/regbank_clr_addr_gen.sv
// rtl/regbank_clr_addr_gen.sv - clear address counter for the register-bank clear engine
//
// Purpose: holds the next entry index to be cleared.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       restart the count at 0 (has priority over adv)
//   adv       advance by one; ignored on the last entry so the count never wraps
//   cnt       current entry index
//   last      cnt == DEPTH-1
module regbank_clr_addr_gen #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] cnt,
  output logic          last
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv && !last) begin
      cnt <= cnt + AW'(1);
    end
  end

endmodule

// File: rtl/regbank_clear_arbiter.sv
// rtl/regbank_clear_arbiter.sv - arbitrates a register bank write port between user writes and bulk clear
//
// Purpose: shares one DEPTH x WIDTH bank write port between a user requester and a
// clear engine that writes {WIDTH{FILL_BIT}} to every entry, one entry per cycle.
// Build option: REGBANK_CLR_USER_PRIO_EN - when defined, user writes are also granted
// during CLEAR (clear address holds for that cycle); otherwise they wait for IDLE.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   clr_req                    pulse: start or restart a bulk clear
//   clr_busy, clr_done         clear in progress / last clear write on the port
//   wr_req, wr_addr, wr_data   user write request
//   wr_gnt                     combinational grant for wr_req
//   wr_err                     registered pulse: granted write addressed beyond DEPTH-1
//   bank_we, bank_addr, bank_wdata  registered bank write port
module regbank_clear_arbiter
  import regbank_ctrl_pkg::*;
#(
  parameter int   DEPTH    = 16,
  parameter int   WIDTH    = 8,
  parameter logic FILL_BIT = 1'b0,
  localparam int  AW       = $clog2(DEPTH > 1 ? DEPTH : 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done,
  input  logic             wr_req,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_gnt,
  output logic             wr_err,
  output logic             bank_we,
  output logic [AW-1:0]    bank_addr,
  output logic [WIDTH-1:0] bank_wdata
);

  localparam logic [FILL_MAX_W-1:0] FILL_FULL = fill_word(WIDTH, FILL_BIT);
  localparam logic [WIDTH-1:0]      FILL      = FILL_FULL[WIDTH-1:0];
  localparam logic [AW:0]           DEPTH_W   = (AW+1)'(DEPTH);

  clr_state_e    state;
  logic [AW-1:0] cnt;
  logic          cnt_last;
  logic          cnt_adv;
  logic          addr_oob;

`ifdef REGBANK_CLR_USER_PRIO_EN
  assign wr_gnt = wr_req && (state != CLR_DONE);
`else
  assign wr_gnt = wr_req && (state == CLR_IDLE);
`endif

  // A user write that wins the port during CLEAR stalls the clear for that cycle.
  assign cnt_adv  = (state == CLR_CLEAR) && !wr_gnt;
  assign addr_oob = ({1'b0, wr_addr} >= DEPTH_W);

  assign clr_busy = (state != CLR_IDLE);
  assign clr_done = (state == CLR_DONE);

  regbank_clr_addr_gen #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_req),
    .adv  (cnt_adv),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLR_IDLE;
      bank_we    <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      wr_err     <= 1'b0;
    end else begin
      bank_we <= 1'b0;
      wr_err  <= 1'b0;

      // Port ownership: a granted user write always wins; otherwise CLEAR writes cnt.
      // Out-of-range user writes are dropped and leave addr/data holding.
      if (wr_gnt) begin
        if (addr_oob) begin
          wr_err <= 1'b1;
        end else begin
          bank_we    <= 1'b1;
          bank_addr  <= wr_addr;
          bank_wdata <= wr_data;
        end
      end else if (state == CLR_CLEAR) begin
        bank_we    <= 1'b1;
        bank_addr  <= cnt;
        bank_wdata <= FILL;
      end

      if (clr_req) begin
        state <= CLR_CLEAR;
      end else begin
        case (state)
          CLR_CLEAR: if (cnt_adv && cnt_last) state <= CLR_DONE;
          CLR_DONE:  state <= CLR_IDLE;
          default:   state <= CLR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regbank_clear_arbiter.sv
// tb/tb_regbank_clear_arbiter.sv - self-checking bench for regbank_clear_arbiter
module tb_regbank_clear_arbiter;

  localparam int   DEPTH    = 16;
  localparam int   WIDTH    = 8;
  localparam logic FILL_BIT = 1'b0;
  localparam int   AW       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr_req, wr_req;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_busy, clr_done, wr_gnt, wr_err, bank_we;
  logic [AW-1:0]    bank_addr;
  logic [WIDTH-1:0] bank_wdata;

  // second instance with a non-power-of-two depth so out-of-range addresses exist
  logic             o_clr_req, o_wr_req;
  logic [3:0]       o_wr_addr;
  logic [WIDTH-1:0] o_wr_data;
  logic             o_clr_busy, o_clr_done, o_wr_gnt, o_wr_err, o_bank_we;
  logic [3:0]       o_bank_addr;
  logic [WIDTH-1:0] o_bank_wdata;

  regbank_clear_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FILL_BIT(FILL_BIT)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_err(wr_err),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata)
  );

  regbank_clear_arbiter #(.DEPTH(12), .WIDTH(WIDTH), .FILL_BIT(1'b1)) dut_oob (
    .clk(clk), .rst(rst), .clr_req(o_clr_req), .clr_busy(o_clr_busy), .clr_done(o_clr_done),
    .wr_req(o_wr_req), .wr_addr(o_wr_addr), .wr_data(o_wr_data), .wr_gnt(o_wr_gnt), .wr_err(o_wr_err),
    .bank_we(o_bank_we), .bank_addr(o_bank_addr), .bank_wdata(o_bank_wdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pos = -1 idle, 0..DEPTH-1 = entry being cleared this cycle, DEPTH = done cycle.
  int               pos;
  logic             m_we, m_err;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_data;

  int               t;
  logic             we_log[64], gnt_log[64], done_log[64], busy_log[64];
  logic [AW-1:0]    addr_log[64];
  logic [WIDTH-1:0] data_log[64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    pos = -1; m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // One cycle: check registered outputs, drive inputs, check combinational outputs,
  // advance the model, move to the next falling edge.
  task automatic step(input logic rq, input logic cr, input int addr, input logic [WIDTH-1:0] data);
    logic g;
    check("bank_we", bank_we, m_we);
    check("wr_err", wr_err, m_err);
    check("bank_addr", bank_addr, m_addr);
    check("bank_wdata", bank_wdata, m_data);
    if (t < 64) begin
      we_log[t] = bank_we; addr_log[t] = bank_addr; data_log[t] = bank_wdata;
    end
    wr_req = rq; clr_req = cr; wr_addr = addr[AW-1:0]; wr_data = data;
    #1;
`ifdef REGBANK_CLR_USER_PRIO_EN
    g = rq && (pos != DEPTH);
`else
    g = rq && (pos == -1);
`endif
    check("wr_gnt", wr_gnt, g);
    check("clr_busy", clr_busy, pos != -1);
    check("clr_done", clr_done, pos == DEPTH);
    if (t < 64) begin
      gnt_log[t] = wr_gnt; done_log[t] = clr_done; busy_log[t] = clr_busy;
    end
    m_we = 1'b0; m_err = 1'b0;
    if (g) begin
      if (addr >= DEPTH) m_err = 1'b1;
      else begin m_we = 1'b1; m_addr = addr[AW-1:0]; m_data = data; end
    end else if (pos >= 0 && pos < DEPTH) begin
      m_we = 1'b1; m_addr = pos[AW-1:0]; m_data = {WIDTH{FILL_BIT}};
    end
    if (cr) pos = 0;
    else if (pos == DEPTH) pos = -1;
    else if (pos >= 0 && !g) pos = (pos == DEPTH - 1) ? DEPTH : pos + 1;
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0);
  endtask

  initial begin
    int n;
    rst = 1'b1; clr_req = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    o_clr_req = 1'b0; o_wr_req = 1'b0; o_wr_addr = '0; o_wr_data = '0;
    t = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(2);

    // clear from cycle 0: writes 2..17, done 17, busy 1..17
    t = 0;
    for (int i = 0; i < 22; i++) step(1'b0, i == 0, 0, '0);
    for (int k = 0; k < 20; k++) begin
      check("t2_we", we_log[k], k >= 2 && k <= 17);
      if (k >= 2 && k <= 17) begin
        check("t2_addr", addr_log[k], k - 2);
        check("t2_data", data_log[k], 8'h00);
      end
      check("t2_done", done_log[k], k == 17);
      check("t2_busy", busy_log[k], k >= 1 && k <= 17);
    end

    // idle user write
    t = 0;
    step(1'b1, 1'b0, 5, 8'hA5);
    idle(2);
    check("t3_gnt", gnt_log[0], 1'b1);
    check("t3_we", we_log[1], 1'b1);
    check("t3_addr", addr_log[1], 5);
    check("t3_data", data_log[1], 8'hA5);
    check("t3_we_after", we_log[2], 1'b0);

`ifndef REGBANK_CLR_USER_PRIO_EN
    // user write held from cycle 3 is blocked until the clear finishes
    t = 0;
    for (int i = 0; i < 22; i++) step(i >= 3 && i <= 18, i == 0, 9, 8'h3C);
    for (int k = 3; k <= 18; k++) check("t4_gnt", gnt_log[k], k == 18);
    check("t4_we", we_log[19], 1'b1);
    check("t4_addr", addr_log[19], 9);
    check("t4_data", data_log[19], 8'h3C);
`else
    // one user write in clear cycle 5 stalls the clear by one cycle
    t = 0;
    for (int i = 0; i < 22; i++) step(i == 5, i == 0, 3, 8'h77);
    check("t6_we", we_log[6], 1'b1);
    check("t6_addr", addr_log[6], 3);
    check("t6_data", data_log[6], 8'h77);
    check("t6_held_addr", addr_log[7], 4);
    check("t6_no_done17", done_log[17], 1'b0);
    check("t6_done18", done_log[18], 1'b1);
`endif

    // restart in clear cycle 8: addresses restart, single clr_done
    t = 0;
    for (int i = 0; i < 40; i++) step(1'b0, i == 0 || i == 8, 0, '0);
    n = 0;
    for (int k = 0; k < 40; k++) if (done_log[k]) n++;
    check("t5_done_cnt", n, 1);
    check("t5_done_at", done_log[25], 1'b1);
    check("t5_addr9", addr_log[9], 7);
    check("t5_addr10", addr_log[10], 0);

    // out-of-range write on the DEPTH=12 instance
    o_wr_req = 1'b1; o_wr_addr = 4'd13; o_wr_data = 8'h55;
    #1;
    check("oob_gnt", o_wr_gnt, 1'b1);
    @(negedge clk);
    o_wr_req = 1'b1; o_wr_addr = 4'd11; o_wr_data = 8'h66;
    check("oob_we", o_bank_we, 1'b0);
    check("oob_err", o_wr_err, 1'b1);
    @(negedge clk);
    o_wr_req = 1'b0;
    check("inrange_we", o_bank_we, 1'b1);
    check("inrange_err", o_wr_err, 1'b0);
    check("inrange_addr", o_bank_addr, 4'd11);
    check("inrange_data", o_bank_wdata, 8'h66);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
           $urandom_range(0, DEPTH - 1), WIDTH'($urandom));
    idle(24);

    // asynchronous reset mid-clear
    step(1'b0, 1'b1, 0, '0);
    idle(5);
    #2 rst = 1'b1;
    #1;
    check("rst_we", bank_we, 1'b0);
    check("rst_addr", bank_addr, 0);
    check("rst_data", bank_wdata, 0);
    check("rst_err", wr_err, 1'b0);
    check("rst_busy", clr_busy, 1'b0);
    check("rst_done", clr_done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    t = 0;
    idle(20);
    n = 0;
    for (int k = 0; k < 20; k++) if (done_log[k] || busy_log[k] || we_log[k]) n++;
    check("rst_no_activity", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
